// File: rtl/sonic_range_filter.sv
// sonic_range_filter
//   Post-processes the ultrasonic detector's echo width. Each falling edge of
//   the echo pin starts one measurement. The block waits for `dis` to settle,
//   rejects out-of-range samples and divides by 58 (us -> cm) one bit per
//   cycle. It then averages the last 2^AVG_LOG2 results and drives a
//   hysteretic obstacle flag.
//
// Ports
//   clk_50m     in   1   system clock (only clock)
//   rst         in   1   synchronous active-high reset
//   echo        in   1   raw asynchronous echo pin
//   dis         in  12   echo width in microseconds
//   dist_cm     out  7   averaged distance in cm (registered)
//   dist_valid  out  1   one-cycle strobe when dist_cm updates (registered)
//   near        out  1   obstacle flag with hysteresis (registered)
//   sample_err  out  1   one-cycle strobe in the CHECK cycle of a rejected sample
//
// Handshake: there is no back-pressure. dist_valid and sample_err are
// fire-and-forget strobes, and they are never high in the same cycle.
module sonic_range_filter #(
    parameter int unsigned ECHO_SETTLE = 64,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned MAX_US      = 4000,
    parameter int unsigned NEAR_CM     = 20,
    parameter int unsigned FAR_CM      = 25
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        echo,
    input  logic [11:0] dis,
    output logic [6:0]  dist_cm,
    output logic        dist_valid,
    output logic        near,
    output logic        sample_err
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned PTR_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned SUM_W = 7 + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;

    localparam logic [12:0]      MAX_L    = 13'(MAX_US);
    localparam logic [6:0]       NEAR_L   = 7'(NEAR_CM);
    localparam logic [6:0]       FAR_L    = 7'(FAR_CM);
    localparam logic [7:0]       SETTLE_L = 8'(ECHO_SETTLE);
    localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CHECK, S_DIV, S_AVG, S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s2_dly_q;
    logic [7:0]        settle_q, settle_d;
    logic [11:0]       samp_q, samp_d;    // sample, then dividend/quotient shift register
    logic [5:0]        rem_q, rem_d;      // partial remainder, always < 58
    logic [3:0]        bit_q, bit_d;
    logic [6:0]        buf_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [6:0]        dist_cm_q, dist_cm_d;
    logic              dist_valid_q, dist_valid_d;
    logic              near_q, near_d;

    logic              fall;
    logic              invalid;
    logic [6:0]        trial;
    logic              ge;
    logic [6:0]        q_cm;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W-1:0]  fill_next;
    logic [6:0]        avg_next;

    assign fall    = s2_dly_q & ~s2_q;
    assign invalid = (samp_q == 12'd0) || ({1'b0, samp_q} >= MAX_L);

    // Restoring division step: the remainder takes the next dividend bit in,
    // and the quotient bit shifts into the freed LSB of samp_q. After 12
    // steps samp_q holds floor(sample/58).
    assign trial = {rem_q, samp_q[11]};
    assign ge    = (trial >= 7'd58);

    // The averaging result is computed from next-state values during AVG so
    // the registered outputs appear in the OUT cycle.
    assign q_cm      = samp_q[6:0];
    assign sum_next  = sum_q + SUM_W'(q_cm) - SUM_W'(buf_q[wptr_q]);
    assign fill_next = (fill_q == DEPTH_L) ? fill_q : fill_q + 1'b1;
    assign avg_next  = 7'(sum_next >> AVG_LOG2);

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        samp_d       = samp_q;
        rem_d        = rem_q;
        bit_d        = bit_q;
        wptr_d       = wptr_q;
        fill_d       = fill_q;
        sum_d        = sum_q;
        dist_cm_d    = dist_cm_q;
        near_d       = near_q;
        dist_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    settle_d = SETTLE_L;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q <= 8'd1) begin
                    samp_d  = dis;
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            S_CHECK: begin
                rem_d = 6'd0;
                bit_d = 4'd0;
                state_d = invalid ? S_IDLE : S_DIV;
            end
            S_DIV: begin
                rem_d  = ge ? 6'(trial - 7'd58) : trial[5:0];
                samp_d = {samp_q[10:0], ge};
                bit_d  = bit_q + 4'd1;
                if (bit_q == 4'd11) state_d = S_AVG;
            end
            S_AVG: begin
                sum_d  = sum_next;
                fill_d = fill_next;
                wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
                if (fill_next == DEPTH_L) begin
                    dist_cm_d    = avg_next;
                    dist_valid_d = 1'b1;
                    if (avg_next <= NEAR_L)     near_d = 1'b1;
                    else if (avg_next >= FAR_L) near_d = 1'b0;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s2_dly_q     <= 1'b0;
            settle_q     <= 8'd0;
            samp_q       <= 12'd0;
            rem_q        <= 6'd0;
            bit_q        <= 4'd0;
            wptr_q       <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            dist_cm_q    <= 7'd0;
            dist_valid_q <= 1'b0;
            near_q       <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= 7'd0;
        end else begin
            state_q      <= state_d;
            s1_q         <= echo;
            s2_q         <= s1_q;
            s2_dly_q     <= s2_q;
            settle_q     <= settle_d;
            samp_q       <= samp_d;
            rem_q        <= rem_d;
            bit_q        <= bit_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            sum_q        <= sum_d;
            dist_cm_q    <= dist_cm_d;
            dist_valid_q <= dist_valid_d;
            near_q       <= near_d;
            if (state_q == S_AVG) buf_q[wptr_q] <= q_cm;
        end
    end

    assign dist_cm    = dist_cm_q;
    assign dist_valid = dist_valid_q;
    assign near       = near_q;
    assign sample_err = (state_q == S_CHECK) && invalid;

endmodule
